// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - machine-level interrupt source controller (msip, mtime, mtimecmp, mip)
//
// Purpose: holds the 64-bit mtime counter, 64-bit mtimecmp and the msip bit
// behind a small request/response register port, and presents MSIP/MTIP/MEIP
// in mip bit positions plus a qualified irq_pending flag.
//
// Optional feature macro: IRQ_CTRL_EXT_SYNC_EN
//   defined   - ext_irq passes through a two-flop synchronizer (MEIP lags 2 clocks)
//   undefined - MEIP is ext_irq directly (source must be synchronous to clk)
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid/req_ready       request handshake; req_we, req_addr, req_wdata
//   rsp_valid/rsp_ready       response handshake; rsp_rdata, rsp_err
//   ext_irq                   external interrupt level
//   mie_in, global_mie        current mie CSR and mstatus.MIE
//   mip_out                   bit 3 MSIP, bit 7 MTIP, bit 11 MEIP
//   irq_pending               global_mie && |(mip_out & mie_in)

module irq_ctrl #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        ext_irq,
  input  logic [31:0] mie_in,
  input  logic        global_mie,
  output logic [31:0] mip_out,
  output logic        irq_pending
);

  localparam int unsigned   PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PSC_MAX = PW'(PRESCALE - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          mtip_q, mtip_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          meip;

  logic          sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
  logic          dec_err;
  logic [31:0]   rd_val;
  logic          accept, wr_en, psc_wrap;

  // Address decode. Misaligned offsets never match a case item, so they
  // fall into the error path together with unmapped ones.
  always_comb begin
    sel_msip    = 1'b0;
    sel_cmp_lo  = 1'b0;
    sel_cmp_hi  = 1'b0;
    sel_time_lo = 1'b0;
    sel_time_hi = 1'b0;
    rd_val      = '0;
    case (req_addr)
      5'h00: begin sel_msip    = 1'b1; rd_val = {31'b0, msip_q};     end
      5'h08: begin sel_cmp_lo  = 1'b1; rd_val = mtimecmp_q[31:0];    end
      5'h0C: begin sel_cmp_hi  = 1'b1; rd_val = mtimecmp_q[63:32];   end
      5'h10: begin sel_time_lo = 1'b1; rd_val = mtime_q[31:0];       end
      5'h14: begin sel_time_hi = 1'b1; rd_val = mtime_q[63:32];      end
      default: ;
    endcase
    dec_err = ~(sel_msip | sel_cmp_lo | sel_cmp_hi | sel_time_lo | sel_time_hi);
  end

  assign accept = (state_q == IDLE) && req_valid;
  assign wr_en  = accept && req_we && !dec_err;

  // Bus FSM: read data is captured from the pre-edge register value.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = RESP;
          rdata_d = (req_we || dec_err) ? 32'h0 : rd_val;
          err_d   = dec_err;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Timer datapath. A write to one mtime half replaces only that half; the
  // other half keeps its pre-edge value (no carry from a same-cycle tick),
  // and the prescaler restarts so the next increment is a full period away.
  assign psc_wrap = (psc_q == PSC_MAX);

  always_comb begin
    psc_d      = psc_wrap ? '0 : psc_q + 1'b1;
    mtime_d    = psc_wrap ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    mtip_d     = (mtime_q >= mtimecmp_q);
    if (wr_en) begin
      if (sel_msip)   msip_d            = req_wdata[0];
      if (sel_cmp_lo) mtimecmp_d[31:0]  = req_wdata;
      if (sel_cmp_hi) mtimecmp_d[63:32] = req_wdata;
      if (sel_time_lo) begin
        mtime_d = {mtime_q[63:32], req_wdata};
        psc_d   = '0;
      end
      if (sel_time_hi) begin
        mtime_d = {req_wdata, mtime_q[31:0]};
        psc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
      psc_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      mtip_q     <= mtip_d;
      psc_q      <= psc_d;
    end
  end

`ifdef IRQ_CTRL_EXT_SYNC_EN
  logic [1:0] ext_sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ext_sync_q <= '0;
    end else begin
      ext_sync_q <= {ext_sync_q[0], ext_irq};
    end
  end

  assign meip = ext_sync_q[1];
`else
  assign meip = ext_irq;
`endif

  always_comb begin
    mip_out     = '0;
    mip_out[3]  = msip_q;
    mip_out[7]  = mtip_q;
    mip_out[11] = meip;
  end

  assign irq_pending = global_mie && (|(mip_out & mie_in));

endmodule
